// File: rtl/bmp_pixel_processor_if.sv
// Stream bundle for the BMP pixel processor: file words in, processed pixels out.
// The slave modport is the processor's view; master is the feeding/consuming side.
interface bmp_pixel_processor_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] slv_data;
  logic                  slv_data_valid;
  logic                  slv_ready;
  logic [1:0]            slv_mode;
  logic [7:0]            slv_proc_val;
  logic [23:0]           mstr_data;
  logic                  mstr_data_valid;
  logic                  mstr_ready;
  logic                  mstr_cmplt;

  modport slave (
    input  slv_data, slv_data_valid, slv_mode, slv_proc_val, mstr_ready,
    output slv_ready, mstr_data, mstr_data_valid, mstr_cmplt
  );

  modport master (
    output slv_data, slv_data_valid, slv_mode, slv_proc_val, mstr_ready,
    input  slv_ready, mstr_data, mstr_data_valid, mstr_cmplt
  );
endinterface

// File: rtl/bmp_pixel_processor.sv
// Streaming 24-bit BMP decoder: parses the header, strips row padding and applies
// a per-component colour operation, one file byte per cycle.
module bmp_pixel_processor #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bmp_pixel_processor_if.slave bus,
  output logic [DIM_W-1:0]     img_width,
  output logic [DIM_W-1:0]     img_height,
  output logic                 hdr_err
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(BYTES + 1);

  typedef enum logic [2:0] {HDR, SKIP, PIX, TAIL, ERR} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] wbuf;
  logic [CW-1:0]         wcnt;
  logic                  ready_q;
  logic [31:0]           bcnt;
  logic [15:0]           sig;
  logic [31:0]           file_size, data_off, width, height;
  logic [7:0]            bc_lo;
  logic [1:0]            mode;
  logic [7:0]            pval;
  logic [DIM_W-1:0]      col, row;
  logic [1:0]            phase, pad_left;
  logic [7:0]            b_byte, g_byte;
  logic [23:0]           out_data;
  logic                  out_valid, out_cmplt;

  logic [7:0] cur;
  logic       accept, stall, can_take, consume, drop, hdr_ok;
  logic       col_last, row_last, pix_load;
  logic [1:0] pad_w;

  function automatic logic [7:0] apply_op(input logic [1:0] m, input logic [7:0] v,
                                          input logic [7:0] c);
    logic [8:0] s;
    s = {1'b0, c} + {1'b0, v};
    case (m)
      2'b01:   apply_op = s[8] ? 8'hFF : s[7:0];
      2'b10:   apply_op = (c < v) ? 8'h00 : c - v;
      2'b11:   apply_op = ~c;
      default: apply_op = c;
    endcase
  endfunction

  assign cur      = wbuf[DATA_WIDTH-1 -: 8];
  assign accept   = ready_q && bus.slv_data_valid;
  assign stall    = out_valid && !bus.mstr_ready;
  assign can_take = (wcnt != '0) && !stall;
  assign col_last = (col == img_width - DIM_W'(1));
  assign row_last = (row == img_height - DIM_W'(1));
  assign pad_w    = img_width[1:0];
  assign pix_load = consume && (state == PIX) && (pad_left == 2'd0) && (phase == 2'd2);

  // Byte 29 completes the bitcount, so its high byte comes straight from the lane.
  assign hdr_ok = (sig == 16'h4D42) && ({cur, bc_lo} == 16'd24) &&
                  (width != 32'd0) && (height != 32'd0) && !height[31] &&
                  ((width >> DIM_W) == 32'd0) && ((height >> DIM_W) == 32'd0) &&
                  (data_off >= 32'd30);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HDR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    consume  = 1'b0;
    drop     = 1'b0;
    case (state)
      HDR: if (can_take) begin
        consume = 1'b1;
        if (bcnt == 32'd29) state_nx = hdr_ok ? SKIP : ERR;
      end
      SKIP: if (bcnt == data_off) state_nx = PIX;
            else consume = can_take;
      PIX: if (can_take) begin
        consume = 1'b1;
        if (row_last && ((pad_left == 2'd1) ||
            (pad_left == 2'd0 && phase == 2'd2 && col_last && pad_w == 2'd0)))
          state_nx = TAIL;
      end
      TAIL: if (bcnt >= file_size) begin
        state_nx = HDR;
        drop     = 1'b1;
      end else consume = can_take;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf <= '0;  wcnt <= '0;  ready_q <= 1'b1;  bcnt <= '0;
      sig <= '0;  file_size <= '0;  data_off <= '0;  width <= '0;  height <= '0;
      bc_lo <= '0;  mode <= '0;  pval <= '0;  col <= '0;  row <= '0;
      phase <= '0;  pad_left <= '0;  b_byte <= '0;  g_byte <= '0;
      img_width <= '0;  img_height <= '0;  hdr_err <= 1'b0;
      out_data <= '0;  out_valid <= 1'b0;  out_cmplt <= 1'b0;
    end else begin
      // Leftover bytes of a finished file are dropped so the next file starts word-aligned.
      if (accept) begin
        wbuf    <= bus.slv_data;
        wcnt    <= CW'(BYTES);
        ready_q <= (state_nx == ERR);
      end else if (drop) begin
        wcnt    <= '0;
        ready_q <= 1'b1;
      end else if (consume) begin
        wbuf    <= wbuf << 8;
        wcnt    <= wcnt - CW'(1);
        ready_q <= (wcnt == CW'(1)) || (state_nx == ERR);
      end else if (state_nx == ERR) begin
        ready_q <= 1'b1;
      end

      if (drop)         bcnt <= '0;
      else if (consume) bcnt <= bcnt + 32'd1;

      if (state_nx == ERR) hdr_err <= 1'b1;

      if (consume && state == HDR) begin
        case (bcnt[4:0])
          5'd0, 5'd1:                 sig       <= {cur, sig[15:8]};
          5'd2, 5'd3, 5'd4, 5'd5:     file_size <= {cur, file_size[31:8]};
          5'd10, 5'd11, 5'd12, 5'd13: data_off  <= {cur, data_off[31:8]};
          5'd18, 5'd19, 5'd20, 5'd21: width     <= {cur, width[31:8]};
          5'd22, 5'd23, 5'd24, 5'd25: height    <= {cur, height[31:8]};
          5'd28:                      bc_lo     <= cur;
          default: ;
        endcase
      end

      if (state == SKIP && state_nx == PIX) begin
        mode       <= bus.slv_mode;
        pval       <= bus.slv_proc_val;
        img_width  <= width[DIM_W-1:0];
        img_height <= height[DIM_W-1:0];
        col <= '0;  row <= '0;  phase <= '0;  pad_left <= '0;
      end else if (consume && state == PIX) begin
        if (pad_left != 2'd0) begin
          pad_left <= pad_left - 2'd1;
          if (pad_left == 2'd1) row <= row + DIM_W'(1);
        end else begin
          case (phase)
            2'd0:    begin b_byte <= cur; phase <= 2'd1; end
            2'd1:    begin g_byte <= cur; phase <= 2'd2; end
            default: begin
              phase <= 2'd0;
              if (col_last) begin
                col <= '0;
                if (pad_w != 2'd0) pad_left <= pad_w;
                else               row <= row + DIM_W'(1);
              end else col <= col + DIM_W'(1);
            end
          endcase
        end
      end

      if (pix_load) begin
        out_valid <= 1'b1;
        out_data  <= {apply_op(mode, pval, cur), apply_op(mode, pval, g_byte),
                      apply_op(mode, pval, b_byte)};
        out_cmplt <= col_last && row_last;
      end else if (out_valid && bus.mstr_ready) begin
        out_valid <= 1'b0;
        out_cmplt <= 1'b0;
      end
    end
  end

  assign bus.slv_ready       = ready_q;
  assign bus.mstr_data       = out_data;
  assign bus.mstr_data_valid = out_valid;
  assign bus.mstr_cmplt      = out_cmplt;
endmodule

// File: tb/tb_bmp_pixel_processor.sv
// Scoreboard bench for bmp_pixel_processor: directed BMP files with hand-computed
// pixels are queued as expectations and checked by an independent output monitor.
module tb_bmp_pixel_processor;
  logic        clk;
  logic        rst;
  logic [15:0] img_width, img_height;
  logic        hdr_err;

  bmp_pixel_processor_if #(.DATA_WIDTH(32)) bus ();

  bmp_pixel_processor #(.DATA_WIDTH(32), .DIM_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .img_width(img_width), .img_height(img_height), .hdr_err(hdr_err)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [24:0] sb[$];
  logic [7:0]  bq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: every presented pixel must match the head of the scoreboard,
  // including while it is held under back-pressure.
  always @(negedge clk) begin
    if (!rst && bus.mstr_data_valid) begin
      if (sb.size() == 0) begin
        if (bus.mstr_ready) begin
          n_assert++;
          n_fail++;
          $display("[TB] FAIL unexpected_pixel got %h required none", bus.mstr_data);
        end
      end else begin
        n_assert++;
        if ({bus.mstr_cmplt, bus.mstr_data} !== sb[0]) begin
          n_fail++;
          $display("[TB] FAIL pixel got cmplt=%b data=%h required cmplt=%b data=%h",
                   bus.mstr_cmplt, bus.mstr_data, sb[0][24], sb[0][23:0]);
        end
        if (bus.mstr_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic sendWord(input logic [31:0] w);
    int n = 0;
    bus.slv_data       = w;
    bus.slv_data_valid = 1'b1;
    while (!bus.slv_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.slv_ready) begin
      n_assert++;
      n_fail++;
      $display("[TB] FAIL send_timeout got ready=0 required ready=1");
    end
    @(posedge clk);
    #1;
    bus.slv_data_valid = 1'b0;
  endtask

  task automatic applyStimulus();
    while (bq.size() % 4 != 0) bq.push_back(8'h00);
    for (int i = 0; i < bq.size(); i += 4)
      sendWord({bq[i], bq[i+1], bq[i+2], bq[i+3]});
    bq.delete();
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("[TB] FAIL drain_timeout got %0d pending required 0", sb.size());
      sb.delete();
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic putHeader(input logic [31:0] fs, input logic [31:0] doff,
                           input logic [31:0] w, input logic [31:0] h, input logic [31:0] bc);
    for (int i = 0; i < int'(doff); i++) begin
      logic [7:0] v;
      v = 8'h00;
      if (i == 0)                v = 8'h42;
      else if (i == 1)           v = 8'h4D;
      else if (i >= 2 && i <= 5)   v = fs[8*(i-2) +: 8];
      else if (i >= 10 && i <= 13) v = doff[8*(i-10) +: 8];
      else if (i >= 18 && i <= 21) v = w[8*(i-18) +: 8];
      else if (i >= 22 && i <= 25) v = h[8*(i-22) +: 8];
      else if (i == 26)          v = 8'h01;
      else if (i >= 28 && i <= 29) v = bc[8*(i-28) +: 8];
      bq.push_back(v);
    end
  endtask

  task automatic putPixel(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r,
                          input logic [23:0] exp, input logic last);
    bq.push_back(b);
    bq.push_back(g);
    bq.push_back(r);
    sb.push_back({last, exp});
  endtask

  task automatic putFill(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) bq.push_back(v);
  endtask

  task automatic putTail(input int base, input int fsize);
    while (bq.size() - base < fsize) bq.push_back(8'h77);
  endtask

  task automatic put2x2(input int fsize);
    int base;
    base = bq.size();
    putHeader(fsize, 54, 2, 2, 24);
    putPixel(8'h01, 8'h02, 8'h03, 24'h030201, 1'b0);
    putPixel(8'h11, 8'h12, 8'h13, 24'h131211, 1'b0);
    putFill(2, 8'hEE);
    putPixel(8'h21, 8'h22, 8'h23, 24'h232221, 1'b0);
    putPixel(8'h31, 8'h32, 8'h33, 24'h333231, 1'b1);
    putFill(2, 8'hEE);
    putTail(base, fsize);
  endtask

  initial begin
    logic [1:0]  cmode [3];
    logic [23:0] cexp  [3];
    int          base;
    cmode = '{2'b01, 2'b10, 2'b11};
    cexp  = '{24'h0A1AFF, 24'h0006EE, 24'hFFEF07};

    bus.slv_data = '0;  bus.slv_data_valid = 1'b0;  bus.slv_mode = 2'b00;
    bus.slv_proc_val = 8'h00;  bus.mstr_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    $display("[TB] reset values");
    checkOutput("rst_slv_ready", bus.slv_ready, 1);
    checkOutput("rst_valid", bus.mstr_data_valid, 0);
    checkOutput("rst_data", bus.mstr_data, 0);
    checkOutput("rst_cmplt", bus.mstr_cmplt, 0);
    checkOutput("rst_hdr_err", hdr_err, 0);
    checkOutput("rst_width", img_width, 0);
    checkOutput("rst_height", img_height, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] 2x2 pass-through, file_size 70");
    put2x2(70);
    applyStimulus();
    waitDrain();
    checkOutput("width_2x2", img_width, 2);
    checkOutput("height_2x2", img_height, 2);

    $display("[TB] colour operations on a 1x1 image");
    bus.slv_proc_val = 8'h0A;
    for (int m = 0; m < 3; m++) begin
      bus.slv_mode = cmode[m];
      putHeader(58, 54, 1, 1, 24);
      putPixel(8'hF8, 8'h10, 8'h00, cexp[m], 1'b1);
      putFill(1, 8'hEE);
      putTail(0, 58);
      applyStimulus();
      waitDrain();
    end
    bus.slv_mode = 2'b00;

    $display("[TB] back-pressure mid-row on a 3x2 image");
    putHeader(78, 54, 3, 2, 24);
    putPixel(8'hA0, 8'hA1, 8'hA2, 24'hA2A1A0, 1'b0);
    putPixel(8'hB0, 8'hB1, 8'hB2, 24'hB2B1B0, 1'b0);
    putPixel(8'hC0, 8'hC1, 8'hC2, 24'hC2C1C0, 1'b0);
    putFill(3, 8'hEE);
    putPixel(8'hD0, 8'hD1, 8'hD2, 24'hD2D1D0, 1'b0);
    putPixel(8'hE0, 8'hE1, 8'hE2, 24'hE2E1E0, 1'b0);
    putPixel(8'hF0, 8'hF1, 8'hF2, 24'hF2F1F0, 1'b1);
    putFill(3, 8'hEE);
    putTail(0, 78);
    fork
      applyStimulus();
      begin
        int n = 0;
        while (!bus.mstr_data_valid && n < 1000) begin
          @(posedge clk);
          #1;
          n++;
        end
        bus.mstr_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("stall_slv_ready", bus.slv_ready, 0);
        checkOutput("stall_valid", bus.mstr_data_valid, 1);
        bus.mstr_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] back-to-back files, first not word-aligned");
    put2x2(71);
    while (bq.size() % 4 != 0) bq.push_back(8'h00);
    base = bq.size();
    putHeader(58, 54, 1, 1, 24);
    putPixel(8'h40, 8'h50, 8'h60, 24'h605040, 1'b1);
    putFill(1, 8'hEE);
    putTail(base, 58);
    applyStimulus();
    waitDrain();
    checkOutput("width_second", img_width, 1);
    checkOutput("height_second", img_height, 1);

    $display("[TB] bad bitcount header");
    putHeader(58, 54, 1, 1, 8);
    putFill(4, 8'h55);
    applyStimulus();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("err_hdr_err", hdr_err, 1);
    checkOutput("err_slv_ready", bus.slv_ready, 1);
    checkOutput("err_valid", bus.mstr_data_valid, 0);
    sendWord(32'h42_4D_00_00);
    checkOutput("err_ready_after", bus.slv_ready, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("err_rst_hdr_err", hdr_err, 0);
    checkOutput("err_rst_ready", bus.slv_ready, 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset with a pending pixel");
    bus.mstr_ready = 1'b0;
    putHeader(70, 54, 2, 2, 24);
    bq.push_back(8'h01); bq.push_back(8'h02); bq.push_back(8'h03);
    bq.push_back(8'h04); bq.push_back(8'h05); bq.push_back(8'h06);
    applyStimulus();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("pend_valid", bus.mstr_data_valid, 1);
    checkOutput("pend_data", bus.mstr_data, 24'h030201);
    checkOutput("pend_ready", bus.slv_ready, 0);
    #3 rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", bus.mstr_data_valid, 0);
    checkOutput("mid_rst_data", bus.mstr_data, 0);
    checkOutput("mid_rst_ready", bus.slv_ready, 1);
    checkOutput("mid_rst_width", img_width, 0);
    @(negedge clk) rst = 1'b0;
    bus.mstr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bmp_pixel_processor.md
# bmp_pixel_processor

Streaming BMP decoder and per-pixel processor: the second-generation image accelerator front end. It accepts a raw 24-bit BMP file as a word stream on a slave valid/ready port, parses and checks the header, strips row padding, and applies a mode-selected colour operation. Each processed pixel is emitted on a master valid/ready port, and completion is flagged per image. Bus width and dimension limits are parametrised, and back-to-back images are supported.

## Interface
- DATA_WIDTH, 32, input word width; multiple of 8, ≥ 8; BYTES = DATA_WIDTH/8
- DIM_W, 16, width of width/height counters; larger header dimensions are errors
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- slv_data  in  DATA_WIDTH  file bytes; first stream byte in most significant lane [DATA_WIDTH-1 -: 8]
- slv_data_valid  in  1  slv_data valid
- slv_ready  out  1  word accepted when slv_ready & slv_data_valid
- slv_mode  in  2  00 pass, 01 saturating add, 10 saturating subtract, 11 invert
- slv_proc_val  in  8  operand for modes 01/10
- mstr_data  out  24  pixel {R,G,B}, 8 bits each
- mstr_data_valid  out  1  mstr_data valid
- mstr_ready  in  1  downstream accepts pixel
- mstr_cmplt  out  1  one-cycle pulse with the last pixel of an image
- img_width  out  DIM_W  parsed width, valid from PIX entry
- img_height  out  DIM_W  parsed height, valid from PIX entry
- hdr_err  out  1  sticky header error

## Operation
- Word buffer holds BYTES bytes; one byte consumed per cycle, MSB lane first; slv_ready = buffer empty (registered).
- Byte counter bcnt (32 bit) counts bytes consumed in the current file.
- FSM: HDR → SKIP → PIX → TAIL → HDR; any state → ERR.
- HDR: capture header bytes 0..29 little-endian: signature 0-1, file_size 2-5, data_off 10-13, width 18-21, height 22-25, bitcount 28-29. Ignore other bytes.
- Checks at byte 29 (any failure → ERR): signature must be 0x42,0x4D; bitcount must be 24; width and height must be nonzero, height bit31 must be clear, and both must be < 2^DIM_W; data_off must be ≥ 30.
- SKIP: discard bytes until bcnt == data_off. On PIX entry, latch slv_mode and slv_proc_val; changes during an image have no effect.
- PIX: assemble B, G, R (file order), then apply the operation per component c:
  - 01: min(c+proc_val, 255)
  - 10: max(c−proc_val, 0)
  - 11: 255−c
- Row padding: after width pixels, discard pad = width[1:0] bytes, then start the next row. After height rows, go to TAIL.
- TAIL: discard bytes until bcnt == file_size. Bytes left in the current word after the file ends are dropped, so the next file starts word-aligned. Then go to HDR with bcnt = 0.
- If file_size is already ≤ bcnt at TAIL entry, go straight to HDR.
- ERR: hdr_err = 1 and slv_ready = 1, discarding all input; only rst exits ERR.

## Timing
- Reset values:
  - slv_ready 1; mstr_data_valid 0; mstr_data 0; mstr_cmplt 0; hdr_err 0; img_width 0; img_height 0
  - FSM HDR, bcnt 0, buffer empty
- After a word is accepted, its first byte is consumed the next cycle. Sustained rate is one word per BYTES+1 cycles with no stall.
- Pixel output register: mstr_data_valid rises the cycle after the R byte is consumed. Data is held stable while valid & !mstr_ready.
- Back-pressure: if the output register is full and not draining, byte consumption stalls (consumption includes padding and tail bytes). When valid & ready, the register may reload in the same cycle.
- mstr_cmplt is asserted in the same cycle as mstr_data_valid of the image's last pixel. It is held with that pixel until the handshake and deasserts the cycle after.
- rst mid-image: all state returns to reset values immediately. The partial pixel and any pending output are lost.

## Test plan
- Reset: assert rst mid-stream → slv_ready=1, mstr_data_valid=0, hdr_err=0 asynchronously; state is HDR.
- 2×2 image, file_size=70, data_off=54, mode 00, DATA_WIDTH=32 → exactly 4 pixels equal to the file BGR triples reordered as {R,G,B}. The 2 padding bytes per row are skipped, and mstr_cmplt pulses with pixel 4.
- Mode 01, proc_val 0x0A, pixel B=0xF8,G=0x10,R=0x00 → 0x0A1AFF. Mode 10 same input → 0x000006EE. Mode 11 → 0xFFEF07.
- Bitcount 8 in header → ERR with hdr_err=1; no pixels emitted; slv_ready stays 1 until rst.
- mstr_ready low for 20 cycles mid-row → mstr_data stable, slv_ready stays 0 once the buffer fills, no pixel lost or duplicated.
- Two files back-to-back, with the first file_size=71 (not word-aligned) → the second image parses correctly from the next word, and mstr_cmplt pulses twice.
